multicycle_control: RTL

Multicycle main control unit for the MIPS-subset datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, including the 3-bit `UC` ALU-operation class consumed by the ALU control decoder, where `3'b111` means "decode funct". Memory accesses stall on a `MemReady` handshake.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/multicycle_ctrl_decode.sv | 111 +++++++++++
 rtl/multicycle_control.sv | 117 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle MIPS-subset main control unit:
//   - state_e   : 4-bit FSM state encoding (codes 13..15 are unused)
//   - OP_*      : 6-bit opcode constants (IR[31:26])
//   - UC_*      : 3-bit ALU-operation class driven to the ALU control decoder
//   - PCSRC_*   : PCSource mux encodings
//   - ALUB_*    : ALUSrcB mux encodings
// Optional feature macro: MULTICYCLE_ADDI_EN (see multicycle_control).
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] UC_ADD   = 3'b000;
  localparam logic [2:0] UC_SUB   = 3'b001;
  localparam logic [2:0] UC_RTYPE = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // True for the two opcodes that share the MEM_ADDR address computation.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_decode
// Purely combinational output decode for the multicycle control FSM.
//   state_i        in  4  current FSM state
//   mem_ready_i    in  1  memory handshake (only used in FETCH and MEM_WR)
//   *_o            out    datapath enables / mux selects, see multicycle_control
// Optional feature macro: MULTICYCLE_ADDI_EN (enables ADDI_EXEC/ADDI_WB decode).
// ---------------------------------------------------------------------------
module multicycle_ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       mem_to_reg_o,
  output logic       ir_write_o,
  output logic       alu_src_a_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic [1:0] pc_source_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] uc_o,
  output logic       instr_done_o
);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    ir_write_o      = 1'b0;
    alu_src_a_o     = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    pc_source_o     = PCSRC_ALU;
    alu_src_b_o     = ALUB_REG;
    uc_o            = UC_ADD;
    instr_done_o    = 1'b0;

    case (state_i)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = ALUB_FOUR;
        // PC+4 and IR capture only commit in the cycle the fetch completes.
        pc_write_o  = mem_ready_i;
        ir_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        alu_src_b_o = ALUB_IMM_SH2;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUB_IMM;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o  = 1'b1;
        i_or_d_o     = 1'b1;
        instr_done_o = mem_ready_i;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        uc_o        = UC_RTYPE;
      end
      S_R_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        uc_o            = UC_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PCSRC_ALUOUT;
        instr_done_o    = 1'b1;
      end
      S_JUMP: begin
        pc_write_o   = 1'b1;
        pc_source_o  = PCSRC_JUMP;
        instr_done_o = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUB_IMM;
      end
      S_ADDI_WB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
`endif
      default: ; // INIT and unused codes: everything stays 0
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multicycle main control unit for the MIPS-subset datapath. Holds the FSM
// state register and next-state logic; output decode lives in
// multicycle_ctrl_decode.
//   clk, rst_n     in      clock, asynchronous active-low reset
//   Opcode         in  6   IR[31:26]
//   MemReady       in  1   memory completed the current access this cycle
//   PCWrite .. RegDst out 1 datapath enables / selects
//   PCSource       out 2   00 ALU, 01 ALUOut, 10 jump target
//   ALUSrcB        out 2   00 B, 01 4, 10 imm, 11 imm<<2
//   UC             out 3   000 add, 001 sub, 111 funct-decoded
//   InstrDone      out 1   pulse on an instruction's final cycle
//   IllegalOp      out 1   pulse in DECODE on an unsupported opcode
//   State          out 4   current state (debug)
// Optional feature macro: MULTICYCLE_ADDI_EN -- when defined, addi is executed
// via ADDI_EXEC/ADDI_WB; otherwise opcode 001000 is illegal.
// ---------------------------------------------------------------------------
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [2:0] UC,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_e state_q, state_d;
  logic   opcode_legal;

  always_comb begin
    opcode_legal = 1'b1;
    case (Opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: opcode_legal = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
      OP_ADDI:                              opcode_legal = 1'b1;
`endif
      default:                              opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem_op(Opcode))       state_d = S_MEM_ADDR;
        else if (Opcode == OP_RTYPE) state_d = S_R_EXEC;
        else if (Opcode == OP_BEQ)   state_d = S_BRANCH;
        else if (Opcode == OP_J)     state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
        else if (Opcode == OP_ADDI)  state_d = S_ADDI_EXEC;
`endif
        else                         state_d = S_FETCH;
      end
      // IR is stable here, so the lw/sw split can use the live opcode.
      S_MEM_ADDR: state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = MemReady ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = MemReady ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
`endif
      default:    state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  multicycle_ctrl_decode u_decode (
    .state_i         (state_q),
    .mem_ready_i     (MemReady),
    .pc_write_o      (PCWrite),
    .pc_write_cond_o (PCWriteCond),
    .i_or_d_o        (IorD),
    .mem_read_o      (MemRead),
    .mem_write_o     (MemWrite),
    .mem_to_reg_o    (MemtoReg),
    .ir_write_o      (IRWrite),
    .alu_src_a_o     (ALUSrcA),
    .reg_write_o     (RegWrite),
    .reg_dst_o       (RegDst),
    .pc_source_o     (PCSource),
    .alu_src_b_o     (ALUSrcB),
    .uc_o            (UC),
    .instr_done_o    (InstrDone)
  );

  assign IllegalOp = (state_q == S_DECODE) && !opcode_legal;
  assign State     = state_q;

endmodule
